snake_engine: RTL

Parametrised grid snake core that replaces the free-running highlight cursor of the top level with a real game model. It holds the snake body as a circular position buffer plus a cell-occupancy bitmap, advances one cell every FRAME_DIV frames, handles direction changes, growth on food and self-collision, and serves a per-cell occupancy query to the VGA pixel path. It sits between the `vga` timing block (which supplies `frame_tick`) and the colour output logic.

---
 rtl/snake_engine.sv | 328 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/snake_engine.sv
// snake_engine
// Grid snake game core. Keeps the snake body as a circular buffer of cell
// positions plus a per-cell occupancy bitmap. The snake advances one cell every
// FRAME_DIV frame ticks, applies the latest legal direction request, grows on
// food and stops on self-collision. A registered per-cell occupancy lookup
// feeds the VGA pixel path.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   frame_tick_i   one-cycle pulse per video frame
//   restart_i      one-cycle pulse, re-initialises the game from any state
//   dir_valid_i    qualifies dir_req_i
//   dir_req_i      requested direction: 0=right 1=down 2=left 3=up
//   food_x_i/_y_i  current food cell
//   query_x_i/_y_i cell looked up for the pixel path
//   query_body_o   occupancy of the queried cell, one cycle later
//   head_x_o/_y_o  current head cell
//   length_o       current body length
//   food_eaten_o   one-cycle pulse when a growing move commits
//   step_pulse_o   one-cycle pulse when any move commits
//   game_over_o    high while the game is frozen after a collision
//   ready_o        high while waiting for the next step
module snake_engine #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int MAX_LEN   = 64,
  parameter int START_LEN = 3,
  parameter int FRAME_DIV = 30,
  localparam int X_BITS = $clog2(GRID_W),
  localparam int Y_BITS = $clog2(GRID_H),
  localparam int L_BITS = $clog2(MAX_LEN) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              frame_tick_i,
  input  logic              restart_i,
  input  logic              dir_valid_i,
  input  logic [1:0]        dir_req_i,
  input  logic [X_BITS-1:0] food_x_i,
  input  logic [Y_BITS-1:0] food_y_i,
  input  logic [X_BITS-1:0] query_x_i,
  input  logic [Y_BITS-1:0] query_y_i,
  output logic              query_body_o,
  output logic [X_BITS-1:0] head_x_o,
  output logic [Y_BITS-1:0] head_y_o,
  output logic [L_BITS-1:0] length_o,
  output logic              food_eaten_o,
  output logic              step_pulse_o,
  output logic              game_over_o,
  output logic              ready_o
);

  localparam int CELLS    = GRID_W * GRID_H;
  localparam int C_BITS   = $clog2(CELLS);
  localparam int PTR_BITS = $clog2(MAX_LEN);
  localparam int POS_BITS = X_BITS + Y_BITS;
  localparam int D_BITS   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [Y_BITS-1:0] MID_Y = Y_BITS'(GRID_H / 2);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_INIT,
    ST_RUN,
    ST_CALC,
    ST_CHECK,
    ST_COMMIT,
    ST_DEAD
  } state_e;

  state_e              state_q, state_d;
  logic [C_BITS-1:0]   clrCnt_q, clrCnt_d;
  logic [X_BITS-1:0]   segCnt_q, segCnt_d;
  logic [D_BITS-1:0]   divCnt_q, divCnt_d;
  logic [1:0]          dir_q, dir_d;
  logic [1:0]          pendDir_q, pendDir_d;
  logic [X_BITS-1:0]   headX_q, headX_d;
  logic [Y_BITS-1:0]   headY_q, headY_d;
  logic [PTR_BITS-1:0] headPtr_q, headPtr_d;
  logic [L_BITS-1:0]   length_q, length_d;
  logic [X_BITS-1:0]   nextX_q, nextX_d;
  logic [Y_BITS-1:0]   nextY_q, nextY_d;
  logic                grow_q, grow_d;
  logic [X_BITS-1:0]   tailX_q, tailX_d;
  logic [Y_BITS-1:0]   tailY_q, tailY_d;
  logic                stepPulse_q, stepPulse_d;
  logic                foodEaten_q, foodEaten_d;
  logic [CELLS-1:0]    bitmap_q, bitmap_d;
  logic                queryBody_q, queryBody_d;

  logic [POS_BITS-1:0] bodyBuf [MAX_LEN];
  logic                bufWe;
  logic [PTR_BITS-1:0] bufWaddr;
  logic [POS_BITS-1:0] bufWdata;

  logic [X_BITS-1:0]   calcX;
  logic [Y_BITS-1:0]   calcY;
  logic [PTR_BITS-1:0] tailIdx;
  logic [POS_BITS-1:0] tailPos;
  logic                collide;
  logic                dirOpposite;
  logic                queryInRange;

  // Row-major bitmap index of a cell.
  function automatic logic [C_BITS-1:0] cellIdx(input logic [X_BITS-1:0] x,
                                                input logic [Y_BITS-1:0] y);
    return C_BITS'(y) * C_BITS'(GRID_W) + C_BITS'(x);
  endfunction

  // One cell ahead of the head in the pending direction, wrapping at the edges.
  always_comb begin
    calcX = headX_q;
    calcY = headY_q;
    case (pendDir_q)
      2'd0:    calcX = (headX_q == X_BITS'(GRID_W - 1)) ? '0 : headX_q + X_BITS'(1);
      2'd1:    calcY = (headY_q == Y_BITS'(GRID_H - 1)) ? '0 : headY_q + Y_BITS'(1);
      2'd2:    calcX = (headX_q == '0) ? X_BITS'(GRID_W - 1) : headX_q - X_BITS'(1);
      default: calcY = (headY_q == '0) ? Y_BITS'(GRID_H - 1) : headY_q - Y_BITS'(1);
    endcase
  end

  // The tail is the oldest live buffer entry. Entering the tail cell is legal
  // on a non-growing move because the tail vacates that cell in the same step.
  always_comb begin
    tailIdx      = headPtr_q - PTR_BITS'(length_q) + PTR_BITS'(1);
    tailPos      = bodyBuf[tailIdx];
    collide      = bitmap_q[cellIdx(nextX_q, nextY_q)] &&
                   !((nextX_q == tailPos[POS_BITS-1:Y_BITS]) &&
                     (nextY_q == tailPos[Y_BITS-1:0]) && !grow_q);
    dirOpposite  = (dir_req_i == (dir_q ^ 2'd2));
    queryInRange = (32'(query_x_i) < GRID_W) && (32'(query_y_i) < GRID_H);
  end

  // Next-state and datapath updates for the game FSM. restart overrides
  // everything at the end so an in-flight step never partially commits.
  always_comb begin
    state_d     = state_q;
    clrCnt_d    = clrCnt_q;
    segCnt_d    = segCnt_q;
    divCnt_d    = divCnt_q;
    dir_d       = dir_q;
    pendDir_d   = pendDir_q;
    headX_d     = headX_q;
    headY_d     = headY_q;
    headPtr_d   = headPtr_q;
    length_d    = length_q;
    nextX_d     = nextX_q;
    nextY_d     = nextY_q;
    grow_d      = grow_q;
    tailX_d     = tailX_q;
    tailY_d     = tailY_q;
    stepPulse_d = 1'b0;
    foodEaten_d = 1'b0;
    bitmap_d    = bitmap_q;
    bufWe       = 1'b0;
    bufWaddr    = headPtr_q;
    bufWdata    = '0;

    if (dir_valid_i && !dirOpposite) begin
      pendDir_d = dir_req_i;
    end

    case (state_q)
      ST_CLEAR: begin
        bitmap_d[clrCnt_q] = 1'b0;
        if (clrCnt_q == C_BITS'(CELLS - 1)) begin
          clrCnt_d = '0;
          state_d  = ST_INIT;
        end else begin
          clrCnt_d = clrCnt_q + C_BITS'(1);
        end
      end

      ST_INIT: begin
        bitmap_d[cellIdx(segCnt_q, MID_Y)] = 1'b1;
        bufWe     = 1'b1;
        bufWaddr  = PTR_BITS'(segCnt_q);
        bufWdata  = {segCnt_q, MID_Y};
        headX_d   = segCnt_q;
        headY_d   = MID_Y;
        headPtr_d = PTR_BITS'(segCnt_q);
        length_d  = L_BITS'(segCnt_q) + L_BITS'(1);
        if (segCnt_q == X_BITS'(START_LEN - 1)) begin
          segCnt_d = '0;
          state_d  = ST_RUN;
        end else begin
          segCnt_d = segCnt_q + X_BITS'(1);
        end
      end

      ST_RUN: begin
        if (frame_tick_i) begin
          if (divCnt_q == D_BITS'(FRAME_DIV - 1)) begin
            divCnt_d = '0;
            state_d  = ST_CALC;
          end else begin
            divCnt_d = divCnt_q + D_BITS'(1);
          end
        end
      end

      ST_CALC: begin
        dir_d   = pendDir_q;
        nextX_d = calcX;
        nextY_d = calcY;
        grow_d  = (calcX == food_x_i) && (calcY == food_y_i) &&
                  (length_q < L_BITS'(MAX_LEN));
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        tailX_d = tailPos[POS_BITS-1:Y_BITS];
        tailY_d = tailPos[Y_BITS-1:0];
        state_d = collide ? ST_DEAD : ST_COMMIT;
      end

      ST_COMMIT: begin
        headPtr_d = headPtr_q + PTR_BITS'(1);
        bufWe     = 1'b1;
        bufWaddr  = headPtr_q + PTR_BITS'(1);
        bufWdata  = {nextX_q, nextY_q};
        // Clear the tail before setting the head so a head entering the
        // vacating tail cell leaves it occupied.
        if (!grow_q) begin
          bitmap_d[cellIdx(tailX_q, tailY_q)] = 1'b0;
        end
        bitmap_d[cellIdx(nextX_q, nextY_q)] = 1'b1;
        headX_d     = nextX_q;
        headY_d     = nextY_q;
        stepPulse_d = 1'b1;
        if (grow_q) begin
          length_d    = length_q + L_BITS'(1);
          foodEaten_d = 1'b1;
        end
        state_d = ST_RUN;
      end

      ST_DEAD: begin
        state_d = ST_DEAD;
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    if (restart_i) begin
      state_d     = ST_CLEAR;
      clrCnt_d    = '0;
      segCnt_d    = '0;
      divCnt_d    = '0;
      dir_d       = 2'd0;
      pendDir_d   = 2'd0;
      headX_d     = '0;
      headY_d     = '0;
      headPtr_d   = '0;
      length_d    = '0;
      stepPulse_d = 1'b0;
      foodEaten_d = 1'b0;
      bitmap_d    = bitmap_q;
      bufWe       = 1'b0;
    end

    queryBody_d = queryInRange && bitmap_q[cellIdx(query_x_i, query_y_i)];
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_CLEAR;
      clrCnt_q    <= '0;
      segCnt_q    <= '0;
      divCnt_q    <= '0;
      dir_q       <= 2'd0;
      pendDir_q   <= 2'd0;
      headX_q     <= '0;
      headY_q     <= '0;
      headPtr_q   <= '0;
      length_q    <= '0;
      nextX_q     <= '0;
      nextY_q     <= '0;
      grow_q      <= 1'b0;
      tailX_q     <= '0;
      tailY_q     <= '0;
      stepPulse_q <= 1'b0;
      foodEaten_q <= 1'b0;
      bitmap_q    <= '0;
      queryBody_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clrCnt_q    <= clrCnt_d;
      segCnt_q    <= segCnt_d;
      divCnt_q    <= divCnt_d;
      dir_q       <= dir_d;
      pendDir_q   <= pendDir_d;
      headX_q     <= headX_d;
      headY_q     <= headY_d;
      headPtr_q   <= headPtr_d;
      length_q    <= length_d;
      nextX_q     <= nextX_d;
      nextY_q     <= nextY_d;
      grow_q      <= grow_d;
      tailX_q     <= tailX_d;
      tailY_q     <= tailY_d;
      stepPulse_q <= stepPulse_d;
      foodEaten_q <= foodEaten_d;
      bitmap_q    <= bitmap_d;
      queryBody_q <= queryBody_d;
    end
  end

  // Body position buffer; entries are always written before they are read.
  always_ff @(posedge clk_i) begin
    if (bufWe) begin
      bodyBuf[bufWaddr] <= bufWdata;
    end
  end

  assign query_body_o = queryBody_q;
  assign head_x_o     = headX_q;
  assign head_y_o     = headY_q;
  assign length_o     = length_q;
  assign food_eaten_o = foodEaten_q;
  assign step_pulse_o = stepPulse_q;
  assign game_over_o  = (state_q == ST_DEAD);
  assign ready_o      = (state_q == ST_RUN);

endmodule
